// File: rtl/i2c_reg_seq.sv
// Register-burst sequencer in front of a byte-level I2C master: pointer write, then a write burst or a repeated-start read burst.
// Optional watchdog on master edges is enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_reg_seq #(
    parameter int ADDR_SZ     = 7,
    parameter int DATA_SZ     = 8,
    parameter int LEN_SZ      = 4,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               I_START,
    input  logic [ADDR_SZ-1:0] I_DEV_ADDR,
    input  logic [DATA_SZ-1:0] I_REG_ADDR,
    input  logic               I_RW,
    input  logic [LEN_SZ-1:0]  I_LEN,
    input  logic [DATA_SZ-1:0] I_WR_DATA,
    input  logic               I_WR_VALID,
    output logic               O_WR_READY,
    output logic [DATA_SZ-1:0] O_RD_DATA,
    output logic               O_RD_VALID,
    output logic               O_DONE,
    output logic               O_ERR,
    output logic               O_SEQ_BUSY,
    output logic               O_EN,
    output logic [ADDR_SZ-1:0] O_ADDR,
    output logic               O_RW,
    output logic [DATA_SZ-1:0] O_DATA_WR,
    input  logic               I_BUSY,
    input  logic [DATA_SZ-1:0] I_DATA_RD,
    input  logic               I_ACK_FL
);
    localparam int DEPTH = 2 ** LEN_SZ;
    localparam int CW    = LEN_SZ + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic               busy_q;
    logic [CW-1:0]      k_q, k_d, f_q, f_d, len_q, len_d, cnt_q, cnt_d;
    logic               dir_q, dir_d, err_q, err_d, en_q, en_d, rw_q, rw_d;
    logic [ADDR_SZ-1:0] addr_q, addr_d;
    logic [DATA_SZ-1:0] dwr_q, dwr_d, rd_data_q, rd_data_d;
    logic               rd_vld_q, rd_vld_d;
    logic [LEN_SZ-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DATA_SZ-1:0] mem_q [DEPTH];
    logic               rise, fall, push, pop, flush, full;
    logic [CW-1:0]      start_len;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);
    logic [WDW-1:0] wd_q, wd_d;
`endif

    assign rise       = I_BUSY & ~busy_q;
    assign fall       = ~I_BUSY & busy_q;
    assign full       = (cnt_q == CW'(DEPTH));
    assign O_WR_READY = (state_q == IDLE) & ~full & ~I_START;
    assign push       = I_WR_VALID & O_WR_READY;
    assign start_len  = CW'(I_LEN) + CW'(1);

    assign O_RD_DATA  = rd_data_q;
    assign O_RD_VALID = rd_vld_q;
    assign O_DONE     = (state_q == DONE);
    assign O_ERR      = err_q;
    assign O_SEQ_BUSY = (state_q != IDLE);
    assign O_EN       = en_q;
    assign O_ADDR     = addr_q;
    assign O_RW       = rw_q;
    assign O_DATA_WR  = dwr_q;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        f_d       = f_q;
        len_d     = len_q;
        dir_d     = dir_q;
        err_d     = err_q;
        en_d      = en_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        dwr_d     = dwr_q;
        rd_data_d = rd_data_q;
        rd_vld_d  = 1'b0;
        pop       = 1'b0;
        flush     = 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
        wd_d      = wd_q;
`endif
        case (state_q)
            IDLE: begin
                if (I_START) begin
                    err_d = 1'b0;
                    len_d = start_len;
                    dir_d = I_RW;
                    k_d   = '0;
                    f_d   = '0;
`ifdef I2C_SEQ_TIMEOUT_EN
                    wd_d  = '0;
`endif
                    if (!I_RW && (cnt_q < start_len)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        en_d    = 1'b1;
                        addr_d  = I_DEV_ADDR;
                        rw_d    = 1'b0;
                        dwr_d   = I_REG_ADDR;
                        state_d = RUN;
                    end
                end
            end
            RUN, DRAIN: begin
                // Each rise means the master took the current byte; stage the next one.
                if (rise && state_q == RUN) begin
                    k_d = k_q + CW'(1);
                    if (k_d == len_q + CW'(1)) begin
                        en_d    = 1'b0;
                        state_d = DRAIN;
                    end else if (!dir_q) begin
                        pop   = 1'b1;
                        dwr_d = mem_q[rptr_q];
                    end else if (k_d == CW'(1)) begin
                        rw_d = 1'b1;
                    end
                end
                if (fall) begin
                    f_d = f_q + CW'(1);
                    if ((f_q == '0 || !dir_q) && I_ACK_FL) begin
                        err_d   = 1'b1;
                        en_d    = 1'b0;
                        flush   = 1'b1;
                        state_d = DRAIN;
                    end else if (dir_q && f_q != '0) begin
                        rd_data_d = I_DATA_RD;
                        rd_vld_d  = 1'b1;
                    end
                end
                if (state_q == DRAIN && !busy_q && !I_BUSY) begin
                    state_d = DONE;
                end
`ifdef I2C_SEQ_TIMEOUT_EN
                if (rise || fall) begin
                    wd_d = '0;
                end else if (wd_q == WDW'(TIMEOUT_CYC - 1)) begin
                    en_d    = 1'b0;
                    err_d   = 1'b1;
                    flush   = 1'b1;
                    state_d = DONE;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
`endif
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            // push is IDLE-only and pop is RUN-only, so they never coincide
            if (push) begin
                wptr_d = wptr_q + LEN_SZ'(1);
                cnt_d  = cnt_q + CW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + LEN_SZ'(1);
                cnt_d  = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wptr_q] <= I_WR_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            k_q       <= '0;
            f_q       <= '0;
            len_q     <= '0;
            dir_q     <= 1'b0;
            err_q     <= 1'b0;
            en_q      <= 1'b0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            dwr_q     <= '0;
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
`ifdef I2C_SEQ_TIMEOUT_EN
            wd_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            busy_q    <= I_BUSY;
            k_q       <= k_d;
            f_q       <= f_d;
            len_q     <= len_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
            en_q      <= en_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            dwr_q     <= dwr_d;
            rd_data_q <= rd_data_d;
            rd_vld_q  <= rd_vld_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
`ifdef I2C_SEQ_TIMEOUT_EN
            wd_q      <= wd_d;
`endif
        end
    end
endmodule

// File: tb/tb_i2c_reg_seq.sv
// Bench for i2c_reg_seq: behavioural byte-level I2C master plus scoreboards for latched bytes and read data.
module tb_i2c_reg_seq;
    logic       CLK = 1'b0;
    logic       RST;
    logic       I_START;
    logic [6:0] I_DEV_ADDR;
    logic [7:0] I_REG_ADDR;
    logic       I_RW;
    logic [3:0] I_LEN;
    logic [7:0] I_WR_DATA;
    logic       I_WR_VALID;
    logic       O_WR_READY;
    logic [7:0] O_RD_DATA;
    logic       O_RD_VALID;
    logic       O_DONE;
    logic       O_ERR;
    logic       O_SEQ_BUSY;
    logic       O_EN;
    logic [6:0] O_ADDR;
    logic       O_RW;
    logic [7:0] O_DATA_WR;
    logic       I_BUSY;
    logic [7:0] I_DATA_RD;
    logic       I_ACK_FL;

    always #5 CLK = ~CLK;

    i2c_reg_seq dut (
        .CLK(CLK), .RST(RST), .I_START(I_START), .I_DEV_ADDR(I_DEV_ADDR),
        .I_REG_ADDR(I_REG_ADDR), .I_RW(I_RW), .I_LEN(I_LEN), .I_WR_DATA(I_WR_DATA),
        .I_WR_VALID(I_WR_VALID), .O_WR_READY(O_WR_READY), .O_RD_DATA(O_RD_DATA),
        .O_RD_VALID(O_RD_VALID), .O_DONE(O_DONE), .O_ERR(O_ERR), .O_SEQ_BUSY(O_SEQ_BUSY),
        .O_EN(O_EN), .O_ADDR(O_ADDR), .O_RW(O_RW), .O_DATA_WR(O_DATA_WR),
        .I_BUSY(I_BUSY), .I_DATA_RD(I_DATA_RD), .I_ACK_FL(I_ACK_FL)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_lat[$];   // {addr, rw, data} the master should latch
    logic [7:0]  exp_rd[$];
    logic [7:0]  rd_src[$];
    logic [15:0] lat;
    int          nack_fall = 0;
    int          m_falls = 0;
    int          rise_cnt = 0;
    bit          m_busy = 0;
    bit          en_seen = 0;
    logic        err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Master model: latches on busy rise, holds busy 4 cycles, returns ack/data on fall.
    initial begin
        I_BUSY = 1'b0;
        I_ACK_FL = 1'b0;
        I_DATA_RD = 8'h00;
        forever begin
            @(posedge CLK); #1;
            if (O_EN === 1'b1 && !RST) begin
                m_busy = 1;
                rise_cnt++;
                lat = {O_ADDR, O_RW, O_DATA_WR};
                if (exp_lat.size() == 0) check("lat_extra", exp_lat.size(), 1);
                else check("lat", lat, exp_lat.pop_front());
                I_BUSY = 1'b1;
                I_ACK_FL = 1'b0;
                repeat (4) @(posedge CLK);
                #1;
                m_falls++;
                I_BUSY = 1'b0;
                I_ACK_FL = (m_falls == nack_fall);
                if (lat[8] && rd_src.size() > 0) I_DATA_RD = rd_src.pop_front();
                m_busy = 0;
            end
        end
    end

    always @(negedge CLK) begin
        if (O_RD_VALID === 1'b1) begin
            if (exp_rd.size() == 0) check("rd_extra", exp_rd.size(), 1);
            else check("rd_data", O_RD_DATA, exp_rd.pop_front());
        end
        if (O_EN === 1'b1) en_seen = 1;
    end

    task automatic push(input logic [7:0] d);
        @(posedge CLK); #1;
        I_WR_VALID = 1'b1;
        I_WR_DATA = d;
        @(posedge CLK); #1;
        I_WR_VALID = 1'b0;
    endtask

    task automatic start(input logic [6:0] dev, input logic [7:0] rg, input logic rw, input logic [3:0] len);
        rise_cnt = 0;
        m_falls = 0;
        @(posedge CLK); #1;
        I_START = 1'b1;
        I_DEV_ADDR = dev;
        I_REG_ADDR = rg;
        I_RW = rw;
        I_LEN = len;
        @(posedge CLK); #1;
        I_START = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output logic e);
        int n = 0;
        bit seen = 0;
        while (!seen && n < budget) begin
            @(negedge CLK);
            n++;
            if (O_DONE === 1'b1) seen = 1;
        end
        check(tag, seen, 1);
        e = O_ERR;
    endtask

    task automatic wait_master_idle();
        int n = 0;
        while (m_busy && n < 100) begin
            @(posedge CLK);
            n++;
        end
        check("master_idle", m_busy, 0);
        repeat (3) @(posedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        RST = 1'b1;
        I_START = 1'b0;
        I_DEV_ADDR = '0;
        I_REG_ADDR = '0;
        I_RW = 1'b0;
        I_LEN = '0;
        I_WR_DATA = '0;
        I_WR_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        check("rst_flags", {O_EN, O_SEQ_BUSY, O_DONE, O_ERR, O_RD_VALID, O_WR_READY}, 6'b000001);
        check("rst_bus", {O_ADDR, O_RW, O_DATA_WR, O_RD_DATA}, 24'h0);

        // Register write, two data bytes
        push(8'hA5);
        push(8'h5A);
        exp_lat.push_back({7'h50, 1'b0, 8'h10});
        exp_lat.push_back({7'h50, 1'b0, 8'hA5});
        exp_lat.push_back({7'h50, 1'b0, 8'h5A});
        start(7'h50, 8'h10, 1'b0, 4'd1);
        wait_done("wr_done", 200, err);
        check("wr_err", err, 0);
        check("wr_rises", rise_cnt, 3);
        check("wr_lat_left", exp_lat.size(), 0);
        check("wr_en_off", O_EN, 0);
        wait_master_idle();
        start(7'h50, 8'h10, 1'b0, 4'd0);
        wait_done("wr_empty_done", 3, err);
        check("wr_fifo_empty", err, 1);

        // Register read, three bytes via repeated start
        exp_lat.push_back({7'h68, 1'b0, 8'h3B});
        for (int i = 0; i < 3; i++) exp_lat.push_back({7'h68, 1'b1, 8'h3B});
        rd_src = '{8'h11, 8'h22, 8'h33};
        exp_rd = '{8'h11, 8'h22, 8'h33};
        start(7'h68, 8'h3B, 1'b1, 4'd2);
        wait_done("rd_done", 300, err);
        check("rd_err", err, 0);
        check("rd_rises", rise_cnt, 4);
        check("rd_left", exp_rd.size(), 0);
        check("rd_lat_left", exp_lat.size(), 0);
        wait_master_idle();

        // NACK on pointer byte aborts and flushes
        for (int i = 1; i <= 4; i++) push(8'(i));
        exp_lat.push_back({7'h2A, 1'b0, 8'h77});
        nack_fall = 1;
        start(7'h2A, 8'h77, 1'b0, 4'd3);
        wait_done("nack_done", 200, err);
        nack_fall = 0;
        check("nack_err", err, 1);
        check("nack_rises", rise_cnt, 1);
        check("nack_en_off", O_EN, 0);
        wait_master_idle();
        en_seen = 0;
        start(7'h2A, 8'h77, 1'b0, 4'd0);
        wait_done("nack_flush_done", 3, err);
        check("nack_flushed", {err, en_seen}, 2'b10);

        // Too few bytes buffered: immediate error, FIFO contents kept
        push(8'hC3);
        en_seen = 0;
        start(7'h11, 8'h22, 1'b0, 4'd3);
        wait_done("short_done", 2, err);
        check("short_err", err, 1);
        check("short_no_en", en_seen, 0);
        push(8'hC4);
        push(8'hC5);
        push(8'hC6);
        exp_lat.push_back({7'h11, 1'b0, 8'h22});
        for (int i = 0; i < 4; i++) exp_lat.push_back({7'h11, 1'b0, 8'(8'hC3 + i)});
        start(7'h11, 8'h22, 1'b0, 4'd3);
        wait_done("short_kept_done", 300, err);
        check("short_kept_err", err, 0);
        check("short_kept_rises", rise_cnt, 5);
        wait_master_idle();

        // Full FIFO, then reset in the middle of a 16-byte write
        for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
        check("full_not_ready", O_WR_READY, 0);
        exp_lat.push_back({7'h7F, 1'b0, 8'hEE});
        for (int i = 0; i < 16; i++) exp_lat.push_back({7'h7F, 1'b0, 8'(8'h80 + i)});
        start(7'h7F, 8'hEE, 1'b0, 4'd15);
        begin
            int n = 0;
            while (rise_cnt < 3 && n < 200) begin
                @(posedge CLK);
                n++;
            end
            check("rst_mid_rises", rise_cnt >= 3, 1);
        end
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        check("rst_mid_flags", {O_EN, O_SEQ_BUSY, O_DONE, O_ERR, O_RD_VALID, O_WR_READY}, 6'b000001);
        check("rst_mid_bus", {O_ADDR, O_RW, O_DATA_WR}, 16'h0);
        RST = 1'b0;
        wait_master_idle();
        exp_lat.delete();
        start(7'h7F, 8'hEE, 1'b0, 4'd0);
        wait_done("rst_empty_done", 3, err);
        check("rst_fifo_empty", err, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
